commit_stage: RTL and testbench

- In-order retirement unit at the head of the ROB.
- Drives the commit-side write port that the issue stage's register file consumes (wb_reg_wr_en_out / wb_reg_wr_idx_out / wb_reg_wr_data_out).
- Clears maptable entries, performs stores to memory through a req/ack handshake, raises squash/redirect on mispredicted branches, and stops retirement on halt or illegal instructions.

---
 rtl/commit_stage_pkg.sv | 27 ++
 rtl/commit_stage_store_ctrl.sv | 42 ++++
 rtl/commit_stage.sv | 161 ++++++++++++++++
 tb/tb_commit_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_stage_pkg.sv
// Shared types and ISA-level macros for the commit stage.
// Optional build macro: COMMIT_PERF_CNT_EN (stall/squash counters).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

package commit_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STORE_WAIT,
    HALTED
  } COMMIT_STATE;

  typedef struct packed {
    logic              wb_reg_wr_en_out;
    logic [4:0]        wb_reg_wr_idx_out;
    logic [`XLEN-1:0]  wb_reg_wr_data_out;
  } COMMIT_PACKET;

endpackage

// File: rtl/commit_stage_store_ctrl.sv
// Store latch and req/ack handshake for the commit stage.
// Latched values stay stable while the request is pending.
module commit_store_ctrl (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             active,
  input  logic             ack,
  input  logic [`XLEN-1:0] st_addr,
  input  logic [`XLEN-1:0] st_data,
  input  logic [2:0]       st_size,
  output logic             req,
  output logic [`XLEN-1:0] mem_addr,
  output logic [`XLEN-1:0] mem_data,
  output logic [2:0]       mem_size,
  output logic             done
);

  logic [`XLEN-1:0] addr_q;
  logic [`XLEN-1:0] data_q;
  logic [2:0]       size_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
    end else if (start) begin
      addr_q <= st_addr;
      data_q <= st_data;
      size_q <= st_size;
    end
  end

  // active already excludes the reset cycle
  assign req      = active;
  assign done     = active && ack;
  assign mem_addr = active ? addr_q : '0;
  assign mem_data = active ? data_q : '0;
  assign mem_size = active ? size_q : '0;

endmodule

// File: rtl/commit_stage.sv
// In-order retirement at the ROB head: regfile write, maptable clear,
// stores, squash/redirect, halt. Optional: COMMIT_PERF_CNT_EN.
module commit_stage
  import commit_stage_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    head_valid,
  input  logic                    head_ready,
  input  logic [`ROB_TAG_LEN-1:0] head_tag,
  input  logic [4:0]              head_dest_reg_idx,
  input  logic [`XLEN-1:0]        head_value,
  input  logic                    head_wr_mem,
  input  logic [`XLEN-1:0]        head_store_addr,
  input  logic [`XLEN-1:0]        head_store_data,
  input  logic [2:0]              head_mem_size,
  input  logic                    head_mispredict,
  input  logic [`XLEN-1:0]        head_target_pc,
  input  logic                    head_halt,
  input  logic                    head_illegal,
  input  logic                    commit_mem_ack,
  output logic                    rob_retire,
  output logic                    wb_reg_wr_en_out,
  output logic [4:0]              wb_reg_wr_idx_out,
  output logic [`XLEN-1:0]        wb_reg_wr_data_out,
  output logic                    maptable_clear_en,
  output logic [4:0]              maptable_clear_idx,
  output logic [`ROB_TAG_LEN-1:0] maptable_clear_tag,
  output logic                    commit_mem_req,
  output logic [`XLEN-1:0]        commit_mem_addr,
  output logic [`XLEN-1:0]        commit_mem_data,
  output logic [2:0]              commit_mem_size,
  output logic                    squash_out,
  output logic [`XLEN-1:0]        redirect_pc,
  output logic                    halt_out,
  output logic                    illegal_out,
  output logic [CNT_WIDTH-1:0]    retired_count
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]    stall_cycles,
  output logic [CNT_WIDTH-1:0]    squash_count
`endif
);

  COMMIT_STATE          state;
  COMMIT_PACKET         pkt;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 halt_q;
  logic                 ill_q;
  logic                 in_idle;
  logic                 in_wait;
  logic                 head_go;
  logic                 stop;
  logic                 ord_go;
  logic                 st_go;
  logic                 hlt_go;
  logic                 st_done;

  assign in_idle = !reset && (state == IDLE);
  assign in_wait = !reset && (state == STORE_WAIT);
  assign head_go = head_valid && head_ready;
  assign stop    = head_halt || head_illegal;
  assign hlt_go  = in_idle && head_go && stop;
  assign st_go   = in_idle && head_go && !stop && head_wr_mem;
  assign ord_go  = in_idle && head_go && !stop && !head_wr_mem;

  always_comb begin
    pkt = '0;
    if (ord_go && (head_dest_reg_idx != `ZERO_REG)) begin
      pkt.wb_reg_wr_en_out   = 1'b1;
      pkt.wb_reg_wr_idx_out  = head_dest_reg_idx;
      pkt.wb_reg_wr_data_out = head_value;
    end
  end

  assign wb_reg_wr_en_out   = pkt.wb_reg_wr_en_out;
  assign wb_reg_wr_idx_out  = pkt.wb_reg_wr_idx_out;
  assign wb_reg_wr_data_out = pkt.wb_reg_wr_data_out;

  assign maptable_clear_en  = pkt.wb_reg_wr_en_out;
  assign maptable_clear_idx = pkt.wb_reg_wr_idx_out;
  assign maptable_clear_tag =
    pkt.wb_reg_wr_en_out ? head_tag : '0;

  // link write still happens on a mispredicted jump
  assign squash_out  = ord_go && head_mispredict;
  assign redirect_pc = squash_out ? head_target_pc : '0;

  assign rob_retire    = ord_go || hlt_go || st_done;
  assign halt_out      = halt_q && !reset;
  assign illegal_out   = ill_q && !reset;
  assign retired_count = reset ? '0 : cnt_q;

  commit_store_ctrl u_store (
    .clock    (clock),
    .reset    (reset),
    .start    (st_go),
    .active   (in_wait),
    .ack      (commit_mem_ack),
    .st_addr  (head_store_addr),
    .st_data  (head_store_data),
    .st_size  (head_mem_size),
    .req      (commit_mem_req),
    .mem_addr (commit_mem_addr),
    .mem_data (commit_mem_data),
    .mem_size (commit_mem_size),
    .done     (st_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt_q  <= '0;
      halt_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      if (rob_retire)
        cnt_q <= cnt_q + 1'b1;
      unique case (state)
        IDLE: begin
          if (hlt_go) begin
            state  <= HALTED;
            halt_q <= 1'b1;
            ill_q  <= head_illegal;
          end else if (st_go) begin
            state <= STORE_WAIT;
          end
        end
        STORE_WAIT: begin
          if (st_done)
            state <= IDLE;
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] squash_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q  <= '0;
      squash_q <= '0;
    end else begin
      if ((in_idle || in_wait) && head_valid && !rob_retire)
        stall_q <= stall_q + 1'b1;
      if (squash_out)
        squash_q <= squash_q + 1'b1;
    end
  end

  assign stall_cycles = reset ? '0 : stall_q;
  assign squash_count = reset ? '0 : squash_q;
`endif

endmodule

// File: tb/tb_commit_stage.sv
// Directed scoreboard bench for commit_stage.
// Expected outputs are queued at drive time and checked each cycle.
module tb_commit_stage;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    head_valid;
  logic                    head_ready;
  logic [`ROB_TAG_LEN-1:0] head_tag;
  logic [4:0]              head_dest_reg_idx;
  logic [`XLEN-1:0]        head_value;
  logic                    head_wr_mem;
  logic [`XLEN-1:0]        head_store_addr;
  logic [`XLEN-1:0]        head_store_data;
  logic [2:0]              head_mem_size;
  logic                    head_mispredict;
  logic [`XLEN-1:0]        head_target_pc;
  logic                    head_halt;
  logic                    head_illegal;
  logic                    commit_mem_ack;
  logic                    rob_retire;
  logic                    wb_reg_wr_en_out;
  logic [4:0]              wb_reg_wr_idx_out;
  logic [`XLEN-1:0]        wb_reg_wr_data_out;
  logic                    maptable_clear_en;
  logic [4:0]              maptable_clear_idx;
  logic [`ROB_TAG_LEN-1:0] maptable_clear_tag;
  logic                    commit_mem_req;
  logic [`XLEN-1:0]        commit_mem_addr;
  logic [`XLEN-1:0]        commit_mem_data;
  logic [2:0]              commit_mem_size;
  logic                    squash_out;
  logic [`XLEN-1:0]        redirect_pc;
  logic                    halt_out;
  logic                    illegal_out;
  logic [31:0]             retired_count;
`ifdef COMMIT_PERF_CNT_EN
  logic [31:0]             stall_cycles;
  logic [31:0]             squash_count;
`endif

  always #5 clock = ~clock;

  commit_stage #(.CNT_WIDTH(32)) dut (
    .clock              (clock),
    .reset              (reset),
    .head_valid         (head_valid),
    .head_ready         (head_ready),
    .head_tag           (head_tag),
    .head_dest_reg_idx  (head_dest_reg_idx),
    .head_value         (head_value),
    .head_wr_mem        (head_wr_mem),
    .head_store_addr    (head_store_addr),
    .head_store_data    (head_store_data),
    .head_mem_size      (head_mem_size),
    .head_mispredict    (head_mispredict),
    .head_target_pc     (head_target_pc),
    .head_halt          (head_halt),
    .head_illegal       (head_illegal),
    .commit_mem_ack     (commit_mem_ack),
    .rob_retire         (rob_retire),
    .wb_reg_wr_en_out   (wb_reg_wr_en_out),
    .wb_reg_wr_idx_out  (wb_reg_wr_idx_out),
    .wb_reg_wr_data_out (wb_reg_wr_data_out),
    .maptable_clear_en  (maptable_clear_en),
    .maptable_clear_idx (maptable_clear_idx),
    .maptable_clear_tag (maptable_clear_tag),
    .commit_mem_req     (commit_mem_req),
    .commit_mem_addr    (commit_mem_addr),
    .commit_mem_data    (commit_mem_data),
    .commit_mem_size    (commit_mem_size),
    .squash_out         (squash_out),
    .redirect_pc        (redirect_pc),
    .halt_out           (halt_out),
    .illegal_out        (illegal_out),
    .retired_count      (retired_count)
`ifdef COMMIT_PERF_CNT_EN
    ,
    .stall_cycles       (stall_cycles),
    .squash_count       (squash_count)
`endif
  );

  typedef struct {
    logic        retire;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic        clr_en;
    logic [4:0]  clr_idx;
    logic [4:0]  clr_tag;
    logic        req;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic        squash;
    logic [31:0] rpc;
    logic        halt;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_cnt = '0;
  exp_t        e;

  function automatic exp_t z();
    exp_t r;
    r = '{default: '0};
    return r;
  endfunction

  function automatic exp_t ex_wr(input logic [4:0] idx,
                                 input logic [31:0] val,
                                 input logic [4:0] tag);
    exp_t r;
    r = z();
    r.retire  = 1'b1;
    r.wr_en   = 1'b1;
    r.wr_idx  = idx;
    r.wr_data = val;
    r.clr_en  = 1'b1;
    r.clr_idx = idx;
    r.clr_tag = tag;
    return r;
  endfunction

  function automatic exp_t ex_st(input logic [31:0] a,
                                 input logic [31:0] d,
                                 input logic [2:0] s);
    exp_t r;
    r = z();
    r.req  = 1'b1;
    r.addr = a;
    r.data = d;
    r.size = s;
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check();
    exp_t x;
    logic [31:0] c;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    x = sb.pop_front();
    c = reset ? 32'd0 : m_cnt;
    chk("rob_retire", 64'(rob_retire), 64'(x.retire));
    chk("wb_en", 64'(wb_reg_wr_en_out), 64'(x.wr_en));
    chk("wb_idx", 64'(wb_reg_wr_idx_out), 64'(x.wr_idx));
    chk("wb_data", 64'(wb_reg_wr_data_out), 64'(x.wr_data));
    chk("clr_en", 64'(maptable_clear_en), 64'(x.clr_en));
    chk("clr_idx", 64'(maptable_clear_idx), 64'(x.clr_idx));
    chk("clr_tag", 64'(maptable_clear_tag), 64'(x.clr_tag));
    chk("mem_req", 64'(commit_mem_req), 64'(x.req));
    chk("mem_addr", 64'(commit_mem_addr), 64'(x.addr));
    chk("mem_data", 64'(commit_mem_data), 64'(x.data));
    chk("mem_size", 64'(commit_mem_size), 64'(x.size));
    chk("squash", 64'(squash_out), 64'(x.squash));
    chk("redirect", 64'(redirect_pc), 64'(x.rpc));
    chk("halt", 64'(halt_out), 64'(x.halt));
    chk("illegal", 64'(illegal_out), 64'(x.ill));
    chk("count", 64'(retired_count), 64'(c));
    if (reset) m_cnt = '0;
    else if (x.retire) m_cnt = m_cnt + 1;
  endtask

  task automatic cycle(input exp_t x);
    sb.push_back(x);
    #1;
    check();
    @(negedge clock);
  endtask

  task automatic hd(input logic v, input logic r,
                    input logic [4:0] dst,
                    input logic [31:0] val,
                    input logic [4:0] tag,
                    input logic wm, input logic mis,
                    input logic hlt, input logic ill);
    head_valid        = v;
    head_ready        = r;
    head_dest_reg_idx = dst;
    head_value        = val;
    head_tag          = tag;
    head_wr_mem       = wm;
    head_mispredict   = mis;
    head_halt         = hlt;
    head_illegal      = ill;
  endtask

  task automatic st(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [2:0] s);
    head_store_addr = a;
    head_store_data = d;
    head_mem_size   = s;
  endtask

  initial begin
    reset          = 1'b1;
    commit_mem_ack = 1'b0;
    head_target_pc = '0;
    hd(0, 0, 0, 0, 0, 0, 0, 0, 0);
    st(0, 0, 0);
    @(negedge clock);

    // ready head during reset: nothing may fire
    hd(1, 1, 5, 32'h1234, 3, 0, 0, 0, 0);
    cycle(z());
    reset = 1'b0;
    cycle(ex_wr(5, 32'h1234, 3));

    hd(1, 1, 0, 32'h55, 4, 0, 0, 0, 0);
    e = z(); e.retire = 1'b1;
    cycle(e);

    hd(1, 0, 7, 32'h66, 5, 0, 0, 0, 0);
    cycle(z());

    // store with ack low for 3 wait cycles
    hd(1, 1, 0, 0, 6, 1, 0, 0, 0);
    st(32'h100, 32'hAB, 3'd2);
    cycle(z());
    e = ex_st(32'h100, 32'hAB, 3'd2);
    cycle(e);
    cycle(e);
    st(32'h999, 32'hFF, 3'd5);
    cycle(e);
    commit_mem_ack = 1'b1;
    e.retire = 1'b1;
    cycle(e);

    // stray ack in IDLE
    hd(1, 0, 2, 32'h1, 7, 0, 0, 0, 0);
    cycle(z());
    commit_mem_ack = 1'b0;

    hd(1, 1, 1, 32'h40, 7, 0, 1, 0, 0);
    head_target_pc = 32'h200;
    e = ex_wr(1, 32'h40, 7);
    e.squash = 1'b1;
    e.rpc    = 32'h200;
    cycle(e);
    hd(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(z());

    // reset on second STORE_WAIT cycle
    hd(1, 1, 0, 0, 8, 1, 0, 0, 0);
    st(32'h104, 32'hCD, 3'd0);
    cycle(z());
    cycle(ex_st(32'h104, 32'hCD, 3'd0));
    reset = 1'b1;
    cycle(z());
    reset = 1'b0;
    hd(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(z());

    // WFI then ADD that must not retire
    hd(1, 1, 0, 0, 9, 0, 0, 1, 0);
    e = z(); e.retire = 1'b1;
    cycle(e);
    hd(1, 1, 3, 32'h77, 10, 0, 0, 0, 0);
    e = z(); e.halt = 1'b1;
    cycle(e);
    cycle(e);

    reset = 1'b1;
    cycle(z());
    reset = 1'b0;
    hd(1, 1, 3, 0, 11, 0, 0, 0, 1);
    e = z(); e.retire = 1'b1;
    cycle(e);
    hd(1, 1, 3, 32'h77, 12, 0, 0, 0, 0);
    e = z(); e.halt = 1'b1; e.ill = 1'b1;
    cycle(e);
    hd(1, 1, 0, 0, 13, 1, 0, 0, 0);
    commit_mem_ack = 1'b1;
    cycle(e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
